oled_init_sequencer: RTL and testbench

// - Controller that sequences i2c_master for the SSD1306 128x64 OLED panel.
// - After reset, waits out panel power-up, then sends the fixed init command list and clears GDDRAM (1024 x 0x00).
// - Afterwards it streams user pixel bytes (valid/ready) to the panel; one I2C transaction per byte.
// - Sits between the display front-end and i2c_master; the only block that drives i2c_master's request inputs.

---
 rtl/oled_init_sequencer_pkg.sv | 18 +
 rtl/oled_init_rom.sv | 37 +++
 rtl/oled_init_sequencer.sv | 157 +++++++++++++++
 tb/tb_oled_init_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_init_sequencer_pkg.sv
// oled_init_sequencer_pkg: shared constants and FSM encoding for the SSD1306 init sequencer
package oled_init_sequencer_pkg;
    localparam logic [7:0] CTRL_CMD     = 8'h00;
    localparam logic [7:0] CTRL_DATA    = 8'h40;
    localparam logic [6:0] SSD1306_ADDR = 7'h3C;
    localparam int         INIT_LEN     = 25;
    localparam logic [4:0] INIT_LAST    = 5'(INIT_LEN - 1);
    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_CMD_ISSUE,
        ST_CMD_WAIT,
        ST_CLR_ISSUE,
        ST_CLR_WAIT,
        ST_READY,
        ST_PIX_WAIT,
        ST_ERROR
    } state_t;
endpackage

// File: rtl/oled_init_rom.sv
// oled_init_rom: SSD1306 power-on command list, index -> command byte
module oled_init_rom (
    input  logic [4:0] i_idx,
    output logic [7:0] o_cmd
);
    // Fixed init table; indices past the list read as 0
    always_comb begin
        case (i_idx)
            5'd0:    o_cmd = 8'hAE;
            5'd1:    o_cmd = 8'hD5;
            5'd2:    o_cmd = 8'h80;
            5'd3:    o_cmd = 8'hA8;
            5'd4:    o_cmd = 8'h3F;
            5'd5:    o_cmd = 8'hD3;
            5'd6:    o_cmd = 8'h00;
            5'd7:    o_cmd = 8'h40;
            5'd8:    o_cmd = 8'h8D;
            5'd9:    o_cmd = 8'h14;
            5'd10:   o_cmd = 8'h20;
            5'd11:   o_cmd = 8'h00;
            5'd12:   o_cmd = 8'hA1;
            5'd13:   o_cmd = 8'hC8;
            5'd14:   o_cmd = 8'hDA;
            5'd15:   o_cmd = 8'h12;
            5'd16:   o_cmd = 8'h81;
            5'd17:   o_cmd = 8'hCF;
            5'd18:   o_cmd = 8'hD9;
            5'd19:   o_cmd = 8'hF1;
            5'd20:   o_cmd = 8'hDB;
            5'd21:   o_cmd = 8'h40;
            5'd22:   o_cmd = 8'hA4;
            5'd23:   o_cmd = 8'hA6;
            5'd24:   o_cmd = 8'hAF;
            default: o_cmd = 8'h00;
        endcase
    end
endmodule

// File: rtl/oled_init_sequencer.sv
// oled_init_sequencer: drives i2c_master through SSD1306 power-up, init, GDDRAM clear and pixel streaming
module oled_init_sequencer
    import oled_init_sequencer_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR     = SSD1306_ADDR,
    parameter logic [19:0] POWERUP_CYCLES = 20'd800000,
    parameter logic [10:0] CLEAR_BYTES    = 11'd1024,
    parameter logic [1:0]  MAX_RETRIES    = 2'd3
) (
    input  logic       CLK,
    input  logic       NRST,
    input  logic       i2c_busy,
    input  logic       i2c_done,
    input  logic       i2c_nack,
    output logic       i2c_enable,
    output logic [6:0] i2c_slave_addr,
    output logic       i2c_read_write,
    output logic [7:0] i2c_control,
    output logic [7:0] i2c_reg_addr,
    output logic [7:0] i2c_data_write,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic       init_done,
    output logic       error
);
    state_t      r_state, w_state_nxt;
    logic [19:0] r_pwr_cnt, w_pwr_cnt_nxt;
    logic [4:0]  r_cmd_idx, w_cmd_idx_nxt;
    logic [10:0] r_clr_cnt, w_clr_cnt_nxt;
    logic [1:0]  r_retry, w_retry_nxt;
    logic        r_pix_en, w_pix_en_nxt;
    logic [7:0]  r_ctrl, w_ctrl_nxt;
    logic [7:0]  r_reg, w_reg_nxt;
    logic [7:0]  r_dat, w_dat_nxt;
    logic        r_init_done, w_init_done_nxt;
    logic        r_err, w_err_nxt;
    logic [7:0]  w_rom_cmd;
    logic        w_ack;
    logic        w_issue;

    assign w_ack          = i2c_done & ~i2c_nack;
    assign w_issue        = (r_state == ST_CMD_ISSUE || r_state == ST_CLR_ISSUE) && !i2c_busy;
    assign i2c_enable     = w_issue | r_pix_en;
    assign i2c_slave_addr = SLAVE_ADDR;
    assign i2c_read_write = 1'b0;
    assign i2c_control    = r_ctrl;
    assign i2c_reg_addr   = r_reg;
    assign i2c_data_write = r_dat;
    assign pix_ready      = r_state == ST_READY;
    assign init_done      = r_init_done;
    assign error          = r_err;

    // ROM looks at the next index so the command byte is already loaded when the issue state is entered
    oled_init_rom u_rom (
        .i_idx(w_cmd_idx_nxt),
        .o_cmd(w_rom_cmd)
    );

    // Power-up, command index and clear counters; each stops before wrapping because the FSM leaves first
    always_comb begin
        w_pwr_cnt_nxt = (r_state == ST_POWERUP && r_pwr_cnt != POWERUP_CYCLES - 20'd1) ? r_pwr_cnt + 20'd1 : r_pwr_cnt;
        w_cmd_idx_nxt = (r_state == ST_POWERUP) ? 5'd0 :
                        (r_state == ST_CMD_WAIT && w_ack && r_cmd_idx != INIT_LAST) ? r_cmd_idx + 5'd1 : r_cmd_idx;
        w_clr_cnt_nxt = (r_state == ST_CMD_WAIT) ? 11'd0 :
                        (r_state == ST_CLR_WAIT && w_ack && r_clr_cnt != CLEAR_BYTES - 11'd1) ? r_clr_cnt + 11'd1 : r_clr_cnt;
    end

    // Next state, retry bookkeeping and the request fields presented to i2c_master
    always_comb begin
        w_state_nxt     = r_state;
        w_retry_nxt     = r_retry;
        w_pix_en_nxt    = 1'b0;
        w_ctrl_nxt      = r_ctrl;
        w_reg_nxt       = r_reg;
        w_dat_nxt       = r_dat;
        w_init_done_nxt = r_init_done;
        w_err_nxt       = r_err;
        case (r_state)
            ST_POWERUP:   w_state_nxt = (r_pwr_cnt == POWERUP_CYCLES - 20'd1) ? ST_CMD_ISSUE : ST_POWERUP;
            ST_CMD_ISSUE: w_state_nxt = i2c_busy ? ST_CMD_ISSUE : ST_CMD_WAIT;
            ST_CLR_ISSUE: w_state_nxt = i2c_busy ? ST_CLR_ISSUE : ST_CLR_WAIT;
            ST_CMD_WAIT, ST_CLR_WAIT, ST_PIX_WAIT: begin
                if (i2c_done && i2c_nack) begin
                    if (r_retry == MAX_RETRIES) begin
                        w_state_nxt = ST_ERROR;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_retry_nxt  = r_retry + 2'd1;
                        w_state_nxt  = (r_state == ST_CMD_WAIT) ? ST_CMD_ISSUE :
                                       (r_state == ST_CLR_WAIT) ? ST_CLR_ISSUE : ST_PIX_WAIT;
                        w_pix_en_nxt = r_state == ST_PIX_WAIT;
                    end
                end else if (w_ack) begin
                    w_retry_nxt = 2'd0;
                    if (r_state == ST_CMD_WAIT)
                        w_state_nxt = ST_CLR_ISSUE;
                    if (r_state == ST_CMD_WAIT && r_cmd_idx != INIT_LAST)
                        w_state_nxt = ST_CMD_ISSUE;
                    if (r_state == ST_CLR_WAIT)
                        w_state_nxt = (r_clr_cnt == CLEAR_BYTES - 11'd1) ? ST_READY : ST_CLR_ISSUE;
                    if (r_state == ST_CLR_WAIT && r_clr_cnt == CLEAR_BYTES - 11'd1)
                        w_init_done_nxt = 1'b1;
                    if (r_state == ST_PIX_WAIT)
                        w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (pix_valid) begin
                    w_state_nxt  = ST_PIX_WAIT;
                    w_pix_en_nxt = 1'b1;
                    w_ctrl_nxt   = CTRL_DATA;
                    w_dat_nxt    = pix_data;
                end
            end
            ST_ERROR:     w_state_nxt = ST_ERROR;
            default:      w_state_nxt = ST_ERROR;
        endcase
        if (w_state_nxt == ST_CMD_ISSUE) begin
            w_ctrl_nxt = CTRL_CMD;
            w_reg_nxt  = w_rom_cmd;
        end
        if (w_state_nxt == ST_CLR_ISSUE) begin
            w_ctrl_nxt = CTRL_DATA;
            w_dat_nxt  = 8'h00;
        end
    end

    // State, counters and request registers; NRST restarts the whole sequence
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_state     <= ST_POWERUP;
            r_pwr_cnt   <= '0;
            r_cmd_idx   <= '0;
            r_clr_cnt   <= '0;
            r_retry     <= '0;
            r_pix_en    <= 1'b0;
            r_ctrl      <= '0;
            r_reg       <= '0;
            r_dat       <= '0;
            r_init_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pwr_cnt   <= w_pwr_cnt_nxt;
            r_cmd_idx   <= w_cmd_idx_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_pix_en    <= w_pix_en_nxt;
            r_ctrl      <= w_ctrl_nxt;
            r_reg       <= w_reg_nxt;
            r_dat       <= w_dat_nxt;
            r_init_done <= w_init_done_nxt;
            r_err       <= w_err_nxt;
        end
    end
endmodule

// File: tb/tb_oled_init_sequencer.sv
// tb_oled_init_sequencer: directed bench with a 4-cycle i2c_master model
module tb_oled_init_sequencer;
    typedef struct {
        bit         nack;
        logic [7:0] ctrl;
        logic [7:0] rega;
        logic [7:0] dat;
    } txn_t;

    logic       CLK = 1'b0;
    logic       NRST = 1'b0;
    logic       i2c_busy = 1'b0;
    logic       i2c_done = 1'b0;
    logic       i2c_nack = 1'b0;
    logic       i2c_enable;
    logic [6:0] i2c_slave_addr;
    logic       i2c_read_write;
    logic [7:0] i2c_control;
    logic [7:0] i2c_reg_addr;
    logic [7:0] i2c_data_write;
    logic [7:0] pix_data = 8'h00;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    logic       init_done;
    logic       error;

    logic [7:0] rom_b [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
                               8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
                               8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    txn_t       vec [30];
    logic [7:0] log_ctrl [64];
    logic [7:0] log_reg [64];
    logic [7:0] log_dat [64];
    bit         nack_tab [64];
    int         n_log;
    int         cur;
    int         cnt;
    bit         en_s;
    int         checks;
    int         errors;

    oled_init_sequencer #(
        .POWERUP_CYCLES(20'd10),
        .CLEAR_BYTES(11'd4)
    ) dut (
        .CLK(CLK),
        .NRST(NRST),
        .i2c_busy(i2c_busy),
        .i2c_done(i2c_done),
        .i2c_nack(i2c_nack),
        .i2c_enable(i2c_enable),
        .i2c_slave_addr(i2c_slave_addr),
        .i2c_read_write(i2c_read_write),
        .i2c_control(i2c_control),
        .i2c_reg_addr(i2c_reg_addr),
        .i2c_data_write(i2c_data_write),
        .pix_data(pix_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .init_done(init_done),
        .error(error)
    );

    always #5 CLK = ~CLK;

    // Request sampling away from the active edge; every accepted request is logged
    always @(negedge CLK) begin
        en_s = NRST && i2c_enable;
        if (en_s && n_log < 64) begin
            log_ctrl[n_log] = i2c_control;
            log_reg[n_log]  = i2c_reg_addr;
            log_dat[n_log]  = i2c_data_write;
            n_log = n_log + 1;
        end
    end

    // i2c_master model: busy from the edge after enable, done pulse 4 edges later, nack from the plan
    always @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            i2c_busy <= 1'b0;
            i2c_done <= 1'b0;
            i2c_nack <= 1'b0;
            cnt      <= 0;
            cur      <= 0;
        end else begin
            i2c_done <= 1'b0;
            i2c_nack <= 1'b0;
            if (cnt > 1)
                cnt <= cnt - 1;
            else if (cnt == 1) begin
                cnt      <= 0;
                i2c_busy <= 1'b0;
                i2c_done <= 1'b1;
                i2c_nack <= nack_tab[cur];
            end else if (en_s) begin
                cnt      <= 4;
                i2c_busy <= 1'b1;
                cur      <= n_log - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_first(input string nm);
        int k;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!i2c_enable && k < 60);
        chk(nm, k, 10);
    endtask

    task automatic wait_log(input int n);
        for (int i = 0; i < 3000 && n_log < n; i++)
            @(negedge CLK);
        chk("wait_log", n_log >= n, 1);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!i2c_done && k < 100) begin
            @(negedge CLK);
            k++;
        end
        chk("wait_done", i2c_done, 1);
    endtask

    initial begin
        int j;
        checks = 0;
        errors = 0;
        n_log  = 0;
        j = 0;
        for (int i = 0; i < 25; i++) begin
            if (i == 4) begin
                vec[j] = '{1'b1, 8'h00, rom_b[i], 8'h00};
                j++;
            end
            vec[j] = '{1'b0, 8'h00, rom_b[i], 8'h00};
            j++;
        end
        for (int i = 0; i < 4; i++)
            vec[25 + 1 + i] = '{1'b0, 8'h40, 8'h00, 8'h00};
        for (int i = 0; i < 64; i++)
            nack_tab[i] = 1'b0;
        for (int i = 0; i < 30; i++)
            nack_tab[i] = vec[i].nack;

        repeat (3) @(negedge CLK);
        chk("rst_enable", i2c_enable, 0);
        chk("rst_ctrl", i2c_control, 0);
        chk("rst_reg", i2c_reg_addr, 0);
        chk("rst_data", i2c_data_write, 0);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_error", error, 0);
        chk("rst_addr", i2c_slave_addr, 7'h3C);
        chk("rst_rw", i2c_read_write, 0);

        n_log = 0;
        NRST = 1'b1;
        wait_first("first_enable_delay");
        chk("first_ctrl", i2c_control, 8'h00);
        chk("first_reg", i2c_reg_addr, 8'hAE);
        wait_log(30);
        wait_done();
        chk("init_done_before", init_done, 0);
        @(negedge CLK);
        chk("init_done_after", init_done, 1);
        chk("ready_after_clear", pix_ready, 1);
        chk("no_error_after_nack", error, 0);
        chk("init_txn_count", n_log, 30);
        for (int i = 0; i < 30; i++)
            chk($sformatf("txn%0d", i), {log_ctrl[i], (vec[i].ctrl == 8'h00) ? log_reg[i] : log_dat[i]},
                {vec[i].ctrl, (vec[i].ctrl == 8'h00) ? vec[i].rega : vec[i].dat});

        nack_tab[31] = 1'b1;
        pix_data  = 8'hA5;
        pix_valid = 1'b1;
        @(negedge CLK);
        pix_valid = 1'b0;
        chk("pix_ready_drop", pix_ready, 0);
        chk("pix_enable", i2c_enable, 1);
        chk("pix_ctrl", i2c_control, 8'h40);
        chk("pix_data", i2c_data_write, 8'hA5);
        wait_done();
        @(negedge CLK);
        chk("pix_ready_back", pix_ready, 1);
        pix_data  = 8'h3C;
        pix_valid = 1'b1;
        @(negedge CLK);
        pix_valid = 1'b0;
        wait_log(33);
        chk("pix_retry_busy_ready", pix_ready, 0);
        wait_done();
        @(negedge CLK);
        chk("pix_retry_ready_back", pix_ready, 1);
        chk("pix_first_try", log_dat[31], 8'h3C);
        chk("pix_resend", {log_ctrl[32], log_dat[32]}, {8'h40, 8'h3C});
        chk("pix_txn_count", n_log, 33);

        NRST = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 64; i++)
            nack_tab[i] = 1'b0;
        n_log = 0;
        NRST = 1'b1;
        wait_log(27);
        @(negedge CLK);
        chk("mid_clr_ctrl", i2c_control, 8'h40);
        NRST = 1'b0;
        #1;
        chk("nrst_enable", i2c_enable, 0);
        chk("nrst_ctrl", i2c_control, 0);
        chk("nrst_init_done", init_done, 0);
        chk("nrst_pix_ready", pix_ready, 0);
        for (int i = 0; i < 4; i++)
            nack_tab[i] = 1'b1;
        @(negedge CLK);
        n_log = 0;
        NRST = 1'b1;
        wait_first("restart_enable_delay");
        chk("restart_reg", {i2c_control, i2c_reg_addr}, {8'h00, 8'hAE});
        wait_log(4);
        chk("err_before", error, 0);
        wait_done();
        @(negedge CLK);
        chk("err_set", error, 1);
        chk("err_pix_ready", pix_ready, 0);
        repeat (60) @(negedge CLK);
        chk("err_no_more_enables", n_log, 4);
        chk("err_sticky", error, 1);
        chk("err_last_byte", log_reg[3], 8'hAE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
